// File: rtl/can_bit_timing_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// can_bit_timing_ctrl_pkg
//   Shared CAN definitions for the bit-timing controller and the TQ generator:
//   field widths, the integration length, the controller FSM state encoding,
//   the packed TQ-generator configuration and two small helpers.
//   Every raw timing field value n means n+1 time quanta (or prescaler steps).
// ----------------------------------------------------------------------------
package can_bit_timing_ctrl_pkg;

    localparam int CAN_BRP_W      = 6;
    localparam int CAN_TSEG1_W    = 4;
    localparam int CAN_TSEG2_W    = 3;
    localparam int CAN_SJW_W      = 2;
    localparam int CAN_TQPOS_W    = 5;
    localparam int CAN_RSYNC_W    = 3;
    localparam int CAN_INTEG_BITS = 11;

    typedef enum logic [1:0] {
        ST_CONFIG    = 2'd0,
        ST_INTEGRATE = 2'd1,
        ST_IDLE_BUS  = 2'd2,
        ST_ACTIVE    = 2'd3
    } can_state_e;

    // Configuration consumed by the TQ generator.
    typedef struct packed {
        logic [CAN_BRP_W-1:0]   brp;
        logic [CAN_TSEG1_W-1:0] tseg1;
        logic [CAN_TSEG2_W-1:0] tseg2;
        logic [CAN_SJW_W-1:0]   sjw;
    } can_tq_cfg_t;

    localparam can_tq_cfg_t CAN_TQ_CFG_RST = '{
        brp:   6'd0,
        tseg1: 4'd12,
        tseg2: 3'd1,
        sjw:   2'd0
    };

    // Quanta per bit: sync segment + (tseg1+1) + (tseg2+1).
    function automatic logic [CAN_TQPOS_W-1:0] can_total_tq(
        input logic [CAN_TSEG1_W-1:0] tseg1,
        input logic [CAN_TSEG2_W-1:0] tseg2
    );
        return CAN_TQPOS_W'(tseg1) + CAN_TQPOS_W'(tseg2) + CAN_TQPOS_W'(3);
    endfunction

    // The jump width may never exceed phase_seg2; both fields share the n+1
    // encoding so the raw values compare directly.
    function automatic logic [CAN_SJW_W-1:0] can_clip_sjw(
        input logic [CAN_SJW_W-1:0]   sjw,
        input logic [CAN_TSEG2_W-1:0] tseg2
    );
        return ({1'b0, sjw} > tseg2) ? tseg2[CAN_SJW_W-1:0] : sjw;
    endfunction

endpackage

// File: rtl/can_phase_err.sv
// ----------------------------------------------------------------------------
// can_phase_err
//   Combinational phase-error evaluation for a resynchronising edge.
//   Ports:
//     i_edge         honoured edge in this cycle (already qualified)
//     i_tx_dom       local node drives dominant (suppresses lengthening)
//     i_tq_position  TQ index of the edge, 1..total_tq
//     i_tseg1/2,sjw  applied raw timing fields
//     o_resync_len   TQs to add to phase_seg1 (0 = none)
//     o_resync_shr   TQs to remove from phase_seg2 (0 = none)
//   At most one output is nonzero because the two branches are exclusive.
// ----------------------------------------------------------------------------
module can_phase_err
    import can_bit_timing_ctrl_pkg::*;
(
    input  logic                   i_edge,
    input  logic                   i_tx_dom,
    input  logic [CAN_TQPOS_W-1:0] i_tq_position,
    input  logic [CAN_TSEG1_W-1:0] i_tseg1,
    input  logic [CAN_TSEG2_W-1:0] i_tseg2,
    input  logic [CAN_SJW_W-1:0]   i_sjw,
    output logic [CAN_RSYNC_W-1:0] o_resync_len,
    output logic [CAN_RSYNC_W-1:0] o_resync_shr
);

    logic [5:0] w_pos;
    logic [5:0] w_total;
    logic [5:0] w_seg1_end;
    logic [5:0] w_sjw_tq;
    logic [5:0] w_early_err;
    logic [5:0] w_late_err;

    always_comb begin
        w_pos        = 6'(i_tq_position);
        w_total      = 6'(can_total_tq(i_tseg1, i_tseg2));
        // Last TQ of sync + prop + phase_seg1.
        w_seg1_end   = 6'(i_tseg1) + 6'd2;
        w_sjw_tq     = 6'(i_sjw) + 6'd1;
        w_early_err  = w_pos - 6'd1;
        w_late_err   = w_total + 6'd1 - w_pos;
        o_resync_len = '0;
        o_resync_shr = '0;
        // An edge in the sync segment (p=1) carries no phase error.
        if (i_edge && (w_pos >= 6'd2)) begin
            if (w_pos <= w_seg1_end) begin
                if (!i_tx_dom) begin
                    o_resync_len = CAN_RSYNC_W'((w_early_err < w_sjw_tq) ? w_early_err : w_sjw_tq);
                end
            end else if (w_pos <= w_total) begin
                o_resync_shr = CAN_RSYNC_W'((w_late_err < w_sjw_tq) ? w_late_err : w_sjw_tq);
            end
        end
    end

endmodule

// File: rtl/can_bit_timing_ctrl.sv
// ----------------------------------------------------------------------------
// can_bit_timing_ctrl
//   Controls the CAN TQ generator: holds its configuration, integrates onto
//   the bus, and issues hard-sync / resync requests from falling rx edges.
//   Ports:
//     clk, rst_n                       clock, synchronous active-low reset
//     i_cfg_mode, i_cfg_wr             configuration mode and write strobe
//     i_cfg_brp/tseg1/tseg2/sjw        raw timing fields to write
//     i_rx, i_tx_dom                   bus level (0 = dominant), local tx
//     i_frame_done                     end of frame from the protocol engine
//     i_tq_tick, i_bit_tick,
//     i_sample_point, i_tq_position    timing pulses and TQ index from gen
//     o_gen_brp/tseg1/tseg2/sjw        applied generator configuration
//     o_gen_en, o_hard_sync            generator enable, restart pulse
//     o_resync_len, o_resync_shr       phase correction, one cycle
//     o_bus_on, o_cfg_rej              integrated, rejected write pulse
//     o_state                          FSM state for observation
//   Handshakes: all strobes and pulses are single-cycle, active-high and
//   sampled on the rising clk edge; there is no back-pressure anywhere.
//   hard_sync and resync outputs are combinational in the tq_tick cycle.
// ----------------------------------------------------------------------------
module can_bit_timing_ctrl
    import can_bit_timing_ctrl_pkg::*;
#(
    parameter int INTEG_BITS = CAN_INTEG_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cfg_mode,
    input  logic                   i_cfg_wr,
    input  logic [CAN_BRP_W-1:0]   i_cfg_brp,
    input  logic [CAN_TSEG1_W-1:0] i_cfg_tseg1,
    input  logic [CAN_TSEG2_W-1:0] i_cfg_tseg2,
    input  logic [CAN_SJW_W-1:0]   i_cfg_sjw,
    input  logic                   i_rx,
    input  logic                   i_tx_dom,
    input  logic                   i_frame_done,
    input  logic                   i_tq_tick,
    input  logic                   i_bit_tick,
    input  logic                   i_sample_point,
    input  logic [CAN_TQPOS_W-1:0] i_tq_position,
    output logic [CAN_BRP_W-1:0]   o_gen_brp,
    output logic [CAN_TSEG1_W-1:0] o_gen_tseg1,
    output logic [CAN_TSEG2_W-1:0] o_gen_tseg2,
    output logic [CAN_SJW_W-1:0]   o_gen_sjw,
    output logic                   o_gen_en,
    output logic                   o_hard_sync,
    output logic [CAN_RSYNC_W-1:0] o_resync_len,
    output logic [CAN_RSYNC_W-1:0] o_resync_shr,
    output logic                   o_bus_on,
    output logic                   o_cfg_rej,
    output can_state_e             o_state
);

    localparam int CNT_W = $clog2(INTEG_BITS + 1);

    can_state_e       r_state;
    can_state_e       w_state_next;
    can_tq_cfg_t      r_gen_cfg;
    logic             r_cfg_rej;
    logic [CNT_W-1:0] r_integ_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_prev_rx;
    logic             r_edge_seen;
    logic             w_fall;
    logic             w_edge_ok;
    logic             w_hard_sync;
    logic             w_resync_edge;

    assign w_cnt_inc = r_integ_cnt + CNT_W'(1);

    // Recessive-to-dominant transition between consecutive TQ samples.
    assign w_fall = i_tq_tick && r_prev_rx && !i_rx;

    // Only one edge per bit is honoured, and never while leaving for CONFIG,
    // closing a frame, or held in reset.
    assign w_edge_ok = w_fall && !r_edge_seen && rst_n && !i_cfg_mode &&
                       ((r_state == ST_IDLE_BUS) ||
                        ((r_state == ST_ACTIVE) && !i_frame_done));

    assign w_hard_sync   = w_edge_ok && (r_state == ST_IDLE_BUS);
    assign w_resync_edge = w_edge_ok && (r_state == ST_ACTIVE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CONFIG;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_gen_en     = (r_state != ST_CONFIG);
        o_bus_on     = (r_state == ST_IDLE_BUS) || (r_state == ST_ACTIVE);
        o_hard_sync  = w_hard_sync;
        case (r_state)
            ST_CONFIG: begin
                if (!i_cfg_mode) w_state_next = ST_INTEGRATE;
            end
            ST_INTEGRATE: begin
                if (i_sample_point && i_rx && (w_cnt_inc == CNT_W'(INTEG_BITS))) begin
                    w_state_next = ST_IDLE_BUS;
                end
            end
            ST_IDLE_BUS: begin
                if (w_hard_sync) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (i_frame_done) w_state_next = ST_IDLE_BUS;
            end
            default: w_state_next = ST_CONFIG;
        endcase
        // Configuration mode overrides every other transition.
        if (i_cfg_mode) w_state_next = ST_CONFIG;
    end

    // ---------------- configuration ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gen_cfg <= CAN_TQ_CFG_RST;
            r_cfg_rej <= 1'b0;
        end else begin
            r_cfg_rej <= i_cfg_wr && (r_state != ST_CONFIG);
            if (i_cfg_wr && (r_state == ST_CONFIG)) begin
                r_gen_cfg.brp   <= i_cfg_brp;
                r_gen_cfg.tseg1 <= i_cfg_tseg1;
                r_gen_cfg.tseg2 <= i_cfg_tseg2;
                r_gen_cfg.sjw   <= can_clip_sjw(i_cfg_sjw, i_cfg_tseg2);
            end
        end
    end

    // ---------------- integration counter ----------------
    // Held at zero outside INTEGRATE, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_integ_cnt <= '0;
        end else if (r_state != ST_INTEGRATE) begin
            r_integ_cnt <= '0;
        end else if (i_sample_point) begin
            r_integ_cnt <= i_rx ? w_cnt_inc : '0;
        end
    end

    // ---------------- edge tracking ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_rx   <= 1'b1;
            r_edge_seen <= 1'b0;
        end else begin
            if (i_tq_tick) r_prev_rx <= i_rx;
            if (i_bit_tick || (r_state == ST_CONFIG)) begin
                r_edge_seen <= 1'b0;
            end else if (w_edge_ok) begin
                r_edge_seen <= 1'b1;
            end
        end
    end

    can_phase_err u_phase_err (
        .i_edge        (w_resync_edge),
        .i_tx_dom      (i_tx_dom),
        .i_tq_position (i_tq_position),
        .i_tseg1       (r_gen_cfg.tseg1),
        .i_tseg2       (r_gen_cfg.tseg2),
        .i_sjw         (r_gen_cfg.sjw),
        .o_resync_len  (o_resync_len),
        .o_resync_shr  (o_resync_shr)
    );

    assign o_gen_brp   = r_gen_cfg.brp;
    assign o_gen_tseg1 = r_gen_cfg.tseg1;
    assign o_gen_tseg2 = r_gen_cfg.tseg2;
    assign o_gen_sjw   = r_gen_cfg.sjw;
    assign o_cfg_rej   = r_cfg_rej;
    assign o_state     = r_state;

endmodule

// File: tb/tb_can_bit_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_can_bit_timing_ctrl
//   Directed sequence with randomized sub-steps, checked against a reference
//   model of the CAN bit-timing rules expressed in time quanta.
// ----------------------------------------------------------------------------
module tb_can_bit_timing_ctrl;
    import can_bit_timing_ctrl_pkg::*;

    localparam int INTEG = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_cfg_mode = 1'b1;
    logic       i_cfg_wr = 1'b0;
    logic [5:0] i_cfg_brp = '0;
    logic [3:0] i_cfg_tseg1 = '0;
    logic [2:0] i_cfg_tseg2 = '0;
    logic [1:0] i_cfg_sjw = '0;
    logic       i_rx = 1'b1;
    logic       i_tx_dom = 1'b0;
    logic       i_frame_done = 1'b0;
    logic       i_tq_tick = 1'b0;
    logic       i_bit_tick = 1'b0;
    logic       i_sample_point = 1'b0;
    logic [4:0] i_tq_position = 5'd1;

    logic [5:0] o_gen_brp;
    logic [3:0] o_gen_tseg1;
    logic [2:0] o_gen_tseg2;
    logic [1:0] o_gen_sjw;
    logic       o_gen_en;
    logic       o_hard_sync;
    logic [2:0] o_resync_len;
    logic [2:0] o_resync_shr;
    logic       o_bus_on;
    logic       o_cfg_rej;
    can_state_e o_state;

    int total = 0;
    int bad   = 0;

    // Reference model: applied configuration and integration progress.
    int m_brp, m_tseg1, m_tseg2, m_sjw;
    int m_run;
    bit m_bus;

    can_bit_timing_ctrl #(.INTEG_BITS(INTEG)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cfg_mode     (i_cfg_mode),
        .i_cfg_wr       (i_cfg_wr),
        .i_cfg_brp      (i_cfg_brp),
        .i_cfg_tseg1    (i_cfg_tseg1),
        .i_cfg_tseg2    (i_cfg_tseg2),
        .i_cfg_sjw      (i_cfg_sjw),
        .i_rx           (i_rx),
        .i_tx_dom       (i_tx_dom),
        .i_frame_done   (i_frame_done),
        .i_tq_tick      (i_tq_tick),
        .i_bit_tick     (i_bit_tick),
        .i_sample_point (i_sample_point),
        .i_tq_position  (i_tq_position),
        .o_gen_brp      (o_gen_brp),
        .o_gen_tseg1    (o_gen_tseg1),
        .o_gen_tseg2    (o_gen_tseg2),
        .o_gen_sjw      (o_gen_sjw),
        .o_gen_en       (o_gen_en),
        .o_hard_sync    (o_hard_sync),
        .o_resync_len   (o_resync_len),
        .o_resync_shr   (o_resync_shr),
        .o_bus_on       (o_bus_on),
        .o_cfg_rej      (o_cfg_rej),
        .o_state        (o_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Phase correction from the bit layout: sync(1) + seg1(tseg1+1) + seg2(tseg2+1).
    function automatic void ref_resync(input int p, input bit txd, output int len, output int shr);
        int seg1_tq = m_tseg1 + 1;
        int seg2_tq = m_tseg2 + 1;
        int sjw_tq  = m_sjw + 1;
        int bit_tq  = 1 + seg1_tq + seg2_tq;
        int err;
        len = 0;
        shr = 0;
        if (p >= 2 && p <= 1 + seg1_tq) begin
            err = p - 1;
            if (!txd) len = (err < sjw_tq) ? err : sjw_tq;
        end else if (p > 1 + seg1_tq && p <= bit_tq) begin
            err = bit_tq - p + 1;
            shr = (err < sjw_tq) ? err : sjw_tq;
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        i_cfg_wr       = 1'b0;
        i_tq_tick      = 1'b0;
        i_bit_tick     = 1'b0;
        i_sample_point = 1'b0;
        i_frame_done   = 1'b0;
    endtask

    task automatic cfg_write(input int b, input int t1, input int t2, input int s);
        i_cfg_brp   = 6'(b);
        i_cfg_tseg1 = 4'(t1);
        i_cfg_tseg2 = 3'(t2);
        i_cfg_sjw   = 2'(s);
        i_cfg_wr    = 1'b1;
        next_cycle();
    endtask

    task automatic model_accept(input int b, input int t1, input int t2, input int s);
        m_brp   = b;
        m_tseg1 = t1;
        m_tseg2 = t2;
        m_sjw   = (s > t2) ? t2 : s;
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_brp"},   o_gen_brp,   m_brp);
        chk({tag, "_tseg1"}, o_gen_tseg1, m_tseg1);
        chk({tag, "_tseg2"}, o_gen_tseg2, m_tseg2);
        chk({tag, "_sjw"},   o_gen_sjw,   m_sjw);
    endtask

    // One TQ tick; the combinational outputs are captured inside the cycle.
    task automatic tq(input logic rx, input int p, input logic bt, input logic txd,
                      output logic hs, output logic [2:0] len, output logic [2:0] shr);
        i_rx          = rx;
        i_tq_position = 5'(p);
        i_tq_tick     = 1'b1;
        i_bit_tick    = bt;
        i_tx_dom      = txd;
        #2;
        hs  = o_hard_sync;
        len = o_resync_len;
        shr = o_resync_shr;
        next_cycle();
    endtask

    task automatic sample(input logic rx);
        i_rx           = rx;
        i_sample_point = 1'b1;
        next_cycle();
        if (!m_bus) begin
            m_run = rx ? m_run + 1 : 0;
            if (m_run >= INTEG) m_bus = 1'b1;
        end
        chk("integ_bus_on", o_bus_on, m_bus);
    endtask

    task automatic resync_case(input string tag, input int p, input bit txd);
        logic hs;
        logic [2:0] len, shr;
        int el, es;
        tq(1'b1, m_tseg1 + m_tseg2 + 3, 1'b1, 1'b0, hs, len, shr);
        tq(1'b0, p, 1'b0, txd, hs, len, shr);
        ref_resync(p, txd, el, es);
        chk({tag, "_len"}, len, el);
        chk({tag, "_shr"}, shr, es);
        chk({tag, "_hs"},  hs,  0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, o_state,      ST_CONFIG);
        chk({tag, "_brp"},   o_gen_brp,    0);
        chk({tag, "_tseg1"}, o_gen_tseg1,  12);
        chk({tag, "_tseg2"}, o_gen_tseg2,  1);
        chk({tag, "_sjw"},   o_gen_sjw,    0);
        chk({tag, "_en"},    o_gen_en,     0);
        chk({tag, "_bus"},   o_bus_on,     0);
        chk({tag, "_rej"},   o_cfg_rej,    0);
        chk({tag, "_hs"},    o_hard_sync,  0);
        chk({tag, "_len"},   o_resync_len, 0);
        chk({tag, "_shr"},   o_resync_shr, 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic hs;
        logic [2:0] len, shr;
        int b, t1, t2, s, p;
        bit txd;

        // Reset
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk_reset("rst");

        // Configuration writes in CONFIG
        cfg_write(3, 5, 1, 3);
        model_accept(3, 5, 1, 3);
        chk_cfg("cfg_dir");
        chk("cfg_dir_rej", o_cfg_rej, 0);
        for (int i = 0; i < 6; i++) begin
            b  = $urandom_range(0, 63);
            t1 = $urandom_range(0, 15);
            t2 = $urandom_range(0, 7);
            s  = $urandom_range(0, 3);
            cfg_write(b, t1, t2, s);
            model_accept(b, t1, t2, s);
            chk_cfg("cfg_rnd");
        end
        // Working timing: total_tq = 11, phase_seg1 ends at TQ 8, sjw = 2 TQ.
        cfg_write(3, 6, 2, 1);
        model_accept(3, 6, 2, 1);
        chk_cfg("cfg_run");

        // Leave CONFIG
        i_cfg_mode = 1'b0;
        next_cycle();
        chk("integ_state", o_state, ST_INTEGRATE);
        chk("integ_en", o_gen_en, 1);

        // Integration: random prefix that never completes, then 10/1/11
        m_run = 0;
        m_bus = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample((m_run == INTEG - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
        end
        sample(1'b0);
        for (int i = 0; i < 10; i++) sample(1'b1);
        sample(1'b0);
        for (int i = 0; i < 11; i++) sample(1'b1);
        chk("integ_idle", o_state, ST_IDLE_BUS);

        // Hard sync at TQ 6
        tq(1'b1, 5, 1'b0, 1'b0, hs, len, shr);
        chk("idle_no_edge_hs", hs, 0);
        tq(1'b0, 6, 1'b0, 1'b0, hs, len, shr);
        chk("hsync_pulse", hs, 1);
        chk("hsync_len", len, 0);
        chk("hsync_shr", shr, 0);
        chk("hsync_state", o_state, ST_ACTIVE);
        chk("hsync_hs_gone", o_hard_sync, 0);

        // Resync directed points and boundaries
        resync_case("rs_p4", 4, 1'b0);
        resync_case("rs_p10", 10, 1'b0);
        resync_case("rs_p11", 11, 1'b0);
        resync_case("rs_p4_tx", 4, 1'b1);
        resync_case("rs_p1", 1, 1'b0);
        resync_case("rs_p8", 8, 1'b0);
        resync_case("rs_p9", 9, 1'b0);
        for (int i = 0; i < 12; i++) begin
            p   = $urandom_range(1, 11);
            txd = 1'($urandom_range(0, 1));
            resync_case("rs_rnd", p, txd);
        end
        chk("rs_state", o_state, ST_ACTIVE);

        // Two edges in one bit: only the first acts
        resync_case("two_first", 4, 1'b0);
        tq(1'b1, 5, 1'b0, 1'b0, hs, len, shr);
        tq(1'b0, 6, 1'b0, 1'b0, hs, len, shr);
        chk("two_second_len", len, 0);
        chk("two_second_shr", shr, 0);

        // Write while ACTIVE is rejected
        cfg_write(3, 5, 1, 3);
        chk("rej_pulse", o_cfg_rej, 1);
        chk_cfg("rej_keep");
        next_cycle();
        chk("rej_clear", o_cfg_rej, 0);

        // frame_done: edge logic idle in that cycle, back to IDLE_BUS
        tq(1'b1, 11, 1'b1, 1'b0, hs, len, shr);
        i_frame_done = 1'b1;
        tq(1'b0, 4, 1'b0, 1'b0, hs, len, shr);
        chk("fd_len", len, 0);
        chk("fd_hs", hs, 0);
        chk("fd_state", o_state, ST_IDLE_BUS);
        tq(1'b1, 5, 1'b0, 1'b0, hs, len, shr);
        tq(1'b0, 6, 1'b0, 1'b0, hs, len, shr);
        chk("fd_hsync", hs, 1);
        chk("fd_active", o_state, ST_ACTIVE);

        // cfg_mode during ACTIVE
        i_cfg_mode = 1'b1;
        next_cycle();
        chk("cm_state", o_state, ST_CONFIG);
        chk("cm_en", o_gen_en, 0);
        chk("cm_bus", o_bus_on, 0);
        chk_cfg("cm_keep");
        i_cfg_mode = 1'b0;
        next_cycle();
        chk("cm_integ", o_state, ST_INTEGRATE);
        m_run = 0;
        m_bus = 1'b0;
        for (int i = 0; i < 11; i++) sample(1'b1);
        tq(1'b1, 2, 1'b0, 1'b0, hs, len, shr);
        tq(1'b0, 3, 1'b0, 1'b0, hs, len, shr);
        chk("cm_hsync", hs, 1);
        chk("cm_active", o_state, ST_ACTIVE);

        // One-cycle reset in ACTIVE with a concurrent edge
        tq(1'b1, 11, 1'b1, 1'b0, hs, len, shr);
        rst_n = 1'b0;
        tq(1'b0, 4, 1'b0, 1'b0, hs, len, shr);
        chk("rst_mid_len", len, 0);
        chk("rst_mid_hs", hs, 0);
        rst_n = 1'b1;
        #1;
        chk_reset("rst_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
